// File: rtl/jk_excitation_gen.sv
// jk_excitation_gen: turns a stream of desired next-Q vectors into J/K, S/R,
// D and T excitations, tracks the expected Q, and checks the Q fed back from
// the downstream flip-flop bank one cycle after each excitation was applied.

// Per-bit excitation lookup for an accepted target (pure combinational).
module jk_exc_lane #(
    parameter int DC_POLICY = 0
) (
    input  logic cur,
    input  logic nxt,
    output logic j,
    output logic k,
    output logic s,
    output logic r,
    output logic d,
    output logic t
);
    // Map (cur -> nxt) to each flop type's excitation; S=R=1 cannot occur.
    always_comb begin
        d = nxt;
        t = cur ^ nxt;
        s = ~cur & nxt;
        r = cur & ~nxt;
        if (DC_POLICY != 0) begin
            // Toggle-biased: the don't-care side follows the toggle request.
            j = cur ^ nxt;
            k = cur ^ nxt;
        end else begin
            // Hold-biased: don't-cares resolve to 0, same as S/R.
            j = ~cur & nxt;
            k = cur & ~nxt;
        end
    end
endmodule

module jk_excitation_gen #(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_valid,
    input  logic             clr,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] t,
    output logic             exc_valid,
    output logic [WIDTH-1:0] q_model,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // EXC stage state
    logic [WIDTH-1:0] j_q, k_q, s_q, r_q, d_q, t_q, q_model_q;
    logic [WIDTH-1:0] j_d, k_d, s_d, r_d, d_d, t_d, q_model_d;
    logic             exc_valid_q, exc_valid_d;
    // CHK stage state
    logic             chk_pend_q, chk_pend_d;
    logic [WIDTH-1:0] chk_exp_q, chk_exp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Per-lane excitations computed against the model, never against q_fb.
    logic [WIDTH-1:0] lj, lk, ls, lr, ld, lt;
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        jk_exc_lane #(.DC_POLICY(DC_POLICY)) u_lane (
            .cur (q_model_q[i]),
            .nxt (tgt[i]),
            .j   (lj[i]),
            .k   (lk[i]),
            .s   (ls[i]),
            .r   (lr[i]),
            .d   (ld[i]),
            .t   (lt[i])
        );
    end

    logic mismatch;
    assign mismatch = chk_pend_q && (q_fb != chk_exp_q);

    // EXC stage: load excitations on a target, otherwise drive hold on every type.
    always_comb begin
        j_d         = '0;
        k_d         = '0;
        s_d         = '0;
        r_d         = '0;
        t_d         = '0;
        d_d         = q_model_q;
        q_model_d   = q_model_q;
        exc_valid_d = 1'b0;
        if (tgt_valid) begin
            j_d         = lj;
            k_d         = lk;
            s_d         = ls;
            r_d         = lr;
            d_d         = ld;
            t_d         = lt;
            q_model_d   = tgt;
            exc_valid_d = 1'b1;
        end
    end

    // CHK stage: compare one cycle after the excitations were on the bus.
    always_comb begin
        chk_pend_d = exc_valid_q;
        chk_exp_d  = q_model_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        if (clr) begin
            // Clear wins over a same-edge mismatch; that mismatch is dropped.
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any pending check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q         <= '0;
            k_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            t_q         <= '0;
            q_model_q   <= '0;
            exc_valid_q <= 1'b0;
            chk_pend_q  <= 1'b0;
            chk_exp_q   <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            j_q         <= j_d;
            k_q         <= k_d;
            s_q         <= s_d;
            r_q         <= r_d;
            d_q         <= d_d;
            t_q         <= t_d;
            q_model_q   <= q_model_d;
            exc_valid_q <= exc_valid_d;
            chk_pend_q  <= chk_pend_d;
            chk_exp_q   <= chk_exp_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign s         = s_q;
    assign r         = r_q;
    assign d         = d_q;
    assign t         = t_q;
    assign exc_valid = exc_valid_q;
    assign q_model   = q_model_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_jk_excitation_gen.sv
// Directed bench: vector table for the excitation mapping plus hand-written
// sequences for the checker, saturation, clear and mid-stream reset.
module tb_jk_excitation_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tgt;
    logic       tgt_valid;
    logic       clr;
    logic [3:0] fb_xor;
    logic [3:0] q_bank;
    logic [3:0] q_fb;

    logic [3:0] j0, k0, s0, r0, d0, t0, qm0;
    logic       ev0, err0;
    logic [7:0] cnt0;
    logic [3:0] j1, k1, s1, r1, d1, t1, qm1;
    logic       ev1, err1;
    logic [7:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Ideal downstream J/K bank driven by the hold-biased instance.
    always @(posedge clk or posedge rst) begin
        if (rst) q_bank <= 4'b0;
        else     q_bank <= (j0 & ~q_bank) | (~k0 & q_bank);
    end
    assign q_fb = q_bank ^ fb_xor;

    jk_excitation_gen #(.WIDTH(4), .DC_POLICY(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .clr(clr),
        .q_fb(q_fb), .j(j0), .k(k0), .s(s0), .r(r0), .d(d0), .t(t0),
        .exc_valid(ev0), .q_model(qm0), .err(err0), .err_cnt(cnt0));

    jk_excitation_gen #(.WIDTH(4), .DC_POLICY(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .clr(clr),
        .q_fb(q_fb), .j(j1), .k(k1), .s(s1), .r(r1), .d(d1), .t(t1),
        .exc_valid(ev1), .q_model(qm1), .err(err1), .err_cnt(cnt1));

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] j, k, s, r, d, t;
        logic [3:0] jk1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        logic [3:0] nt;

        // from 0000 onward, each row against the previous row's target
        vecs[0] = '{4'b0011, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0011};
        vecs[1] = '{4'b0101, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0101, 4'b0110, 4'b0110};
        vecs[2] = '{4'b1010, 4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b1111, 4'b1111};
        vecs[3] = '{4'b1011, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1011, 4'b0001, 4'b0001};
        vecs[4] = '{4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b1011};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[6] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111};

        // Reset hold with a target presented
        rst = 1'b1; tgt = 4'hF; tgt_valid = 1'b1; clr = 1'b0; fb_xor = 4'b0;
        tick(); tick();
        chk("rst_exc", {j0, k0, s0, r0, d0, t0}, 32'h0);
        chk("rst_ctl", {ev0, qm0, err0, cnt0}, 32'h0);
        rst = 1'b0; tgt_valid = 1'b0; tgt = 4'h0;
        tick();
        chk("idle_after_rst", {ev0, j0, k0, s0, r0, t0, d0, qm0}, 32'h0);

        // Table-driven mapping, back-to-back targets
        for (int i = 0; i < 7; i++) begin
            tgt = vecs[i].tgt; tgt_valid = 1'b1;
            tick();
            chk($sformatf("v%0d_jk", i),   {j0, k0}, {vecs[i].j, vecs[i].k});
            chk($sformatf("v%0d_sr", i),   {s0, r0}, {vecs[i].s, vecs[i].r});
            chk($sformatf("v%0d_dt", i),   {d0, t0}, {vecs[i].d, vecs[i].t});
            chk($sformatf("v%0d_dc1", i),  {j1, k1, s1, r1, d1, t1},
                {vecs[i].jk1, vecs[i].jk1, vecs[i].s, vecs[i].r, vecs[i].d, vecs[i].t});
            chk($sformatf("v%0d_qm", i),   {ev0, qm0}, {1'b1, vecs[i].tgt});
        end
        // Deassert: hold excitations everywhere, D repeats the model
        tgt_valid = 1'b0; tgt = 4'b0000;
        tick();
        chk("hold_exc", {ev0, j0, k0, s0, r0, t0}, 32'h0);
        chk("hold_d", {d0, qm0}, {4'b1111, 4'b1111});
        tick(); tick();
        chk("table_noerr", {err0, cnt0}, 32'h0);

        // 16 random back-to-back targets against the ideal bank
        prev = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            nt = 4'($urandom_range(0, 15));
            tgt = nt; tgt_valid = 1'b1;
            tick();
            chk($sformatf("rnd%0d", i), {j0, k0, d0, t0, qm0},
                {nt & ~prev, ~nt & prev, nt, nt ^ prev, nt});
            prev = nt;
        end
        tgt_valid = 1'b0;
        tick(); tick(); tick();
        chk("rnd_noerr", {err0, cnt0}, 32'h0);

        // Single bad check cycle
        tgt = 4'b0110; tgt_valid = 1'b1;
        tick();                      // edge n: accept
        tgt_valid = 1'b0;
        tick();                      // edge n+1: bank captures
        chk("pre_err", {err0, cnt0}, 32'h0);
        fb_xor = 4'b0001;
        tick();                      // edge n+2: compare
        chk("one_err", {err0, cnt0}, {1'b1, 8'd1});
        fb_xor = 4'b0000;
        tick(); tick(); tick();
        chk("err_sticky", {err0, cnt0}, {1'b1, 8'd1});

        // Clear with no mismatch pending
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_idle", {err0, cnt0}, 32'h0);

        // Saturation: continuous stream, every check mismatches on all bits
        tgt = 4'b0000; tgt_valid = 1'b1; fb_xor = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        chk("cnt_partial", {err0, cnt0}, {1'b1, 8'd8});
        for (int i = 10; i < 300; i++) tick();
        chk("cnt_sat", {err0, cnt0}, {1'b1, 8'd255});
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_wins", {err0, cnt0}, 32'h0);
        tick();
        chk("after_clr", {err0, cnt0}, {1'b1, 8'd1});

        // Drain and clear before the mid-stream reset test
        fb_xor = 4'b0000; tgt_valid = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        tick(); tick();
        chk("drained", {err0, cnt0}, 32'h0);

        // Reset while a bad check is pending
        tgt = 4'b0101; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0; fb_xor = 4'b1111;
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst", {ev0, qm0, err0, cnt0}, 32'h0);
        tick();
        rst = 1'b0; fb_xor = 4'b0000;
        tick();
        chk("rst_drop", {err0, cnt0, qm0}, 32'h0);
        tgt = 4'b1000; tgt_valid = 1'b1;
        tick();
        chk("post_rst_jt", {j0, k0, t0, d0}, {4'b1000, 4'b0000, 4'b1000, 4'b1000});
        tgt_valid = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_noerr", {err0, cnt0}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
